// File: rtl/serial_frame_sequencer8_pkg.sv
// Shared types and constants for the serial frame sequencer.
// Holds the FSM state encoding and the frame length.
package serial_frame_sequencer8_pkg;

  localparam int unsigned FrameBits = 8;
  localparam logic [2:0]  LastBit   = 3'(FrameBits - 1);

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/serial_frame_sequencer8_if.sv
// Parallel-in / serial-out handshake bundle of the frame sequencer.
// The slave modport is the sequencer; the master modport is whoever feeds and drains it.
interface serial_frame_sequencer8_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] sel;
  logic       frame_last;
  logic       busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_bit, out_valid, sel, frame_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_bit, out_valid, sel, frame_last, busy
  );
endinterface

// File: rtl/serial_frame_sequencer8_mux8_1.sv
// Combinational 8:1 multiplexer; {a_i, b_i, c_i} selects one of d0_i..d7_i.
module mux8_1 (
  input  logic d0_i,
  input  logic d1_i,
  input  logic d2_i,
  input  logic d3_i,
  input  logic d4_i,
  input  logic d5_i,
  input  logic d6_i,
  input  logic d7_i,
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);

  always_comb begin
    y_o = d0_i;
    unique case ({a_i, b_i, c_i})
      3'd0: y_o = d0_i;
      3'd1: y_o = d1_i;
      3'd2: y_o = d2_i;
      3'd3: y_o = d3_i;
      3'd4: y_o = d4_i;
      3'd5: y_o = d5_i;
      3'd6: y_o = d6_i;
      3'd7: y_o = d7_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/serial_frame_sequencer8.sv
// Serialises 8-bit words through an 8:1 mux, one bit per handshake.
// A one-word holding buffer lets the next frame start with no idle cycle.
module serial_frame_sequencer8
  import serial_frame_sequencer8_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic                      clk,
  input logic                      rst,
  serial_frame_sequencer8_if.slave bus_io
);

  state_e     state_q, state_d;
  logic [7:0] shift_word_q, shift_word_d;
  logic [7:0] hold_word_q, hold_word_d;
  logic       hold_full_q, hold_full_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  logic       accept;
  logic       take;
  logic       last_bit;
  logic [2:0] sel;
  logic       mux_y;

  assign accept   = bus_io.in_valid && !hold_full_q;
  assign take     = (state_q == StShift) && bus_io.out_ready;
  assign last_bit = (bit_cnt_q == LastBit);

  always_comb begin
    state_d      = state_q;
    shift_word_d = shift_word_q;
    hold_word_d  = hold_word_q;
    hold_full_d  = hold_full_q;
    bit_cnt_d    = bit_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_word_d = bus_io.in_data;
          bit_cnt_d    = '0;
          state_d      = StShift;
        end
      end
      StShift: begin
        if (take && last_bit) begin
          bit_cnt_d = '0;
          if (hold_full_q) begin
            shift_word_d = hold_word_q;
            hold_full_d  = 1'b0;
          end else if (accept) begin
            // Bypass the holding buffer so the new frame follows without a bubble.
            shift_word_d = bus_io.in_data;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (take) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (accept) begin
            hold_word_d = bus_io.in_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      shift_word_q <= '0;
      hold_word_q  <= '0;
      hold_full_q  <= 1'b0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      shift_word_q <= shift_word_d;
      hold_word_q  <= hold_word_d;
      hold_full_q  <= hold_full_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign sel = MSB_FIRST ? ~bit_cnt_q : bit_cnt_q;

  mux8_1 u_mux (
    .d0_i (shift_word_q[0]),
    .d1_i (shift_word_q[1]),
    .d2_i (shift_word_q[2]),
    .d3_i (shift_word_q[3]),
    .d4_i (shift_word_q[4]),
    .d5_i (shift_word_q[5]),
    .d6_i (shift_word_q[6]),
    .d7_i (shift_word_q[7]),
    .a_i  (sel[2]),
    .b_i  (sel[1]),
    .c_i  (sel[0]),
    .y_o  (mux_y)
  );

  assign bus_io.sel        = sel;
  assign bus_io.out_bit    = (state_q == StShift) ? mux_y : IDLE_LEVEL;
  assign bus_io.out_valid  = (state_q == StShift);
  assign bus_io.frame_last = (state_q == StShift) && last_bit;
  assign bus_io.busy       = (state_q == StShift);
  assign bus_io.in_ready   = !hold_full_q;

endmodule

// File: tb/tb_serial_frame_sequencer8.sv
// Bench for serial_frame_sequencer8: an LSB-first/idle-0 and an MSB-first/idle-1 instance
// share one stimulus and are checked every cycle against a word-queue model.
module tb_serial_frame_sequencer8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_frame_sequencer8_if bus0 ();
  serial_frame_sequencer8_if bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  serial_frame_sequencer8 #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus0)
  );

  serial_frame_sequencer8 #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus1)
  );

  // Model: queue holds the word being sent (front) plus at most one waiting word.
  logic [7:0] mq[$];
  int         midx = 0;
  bit         m_acc, m_tk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      midx = 0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_tk  = (mq.size() > 0) && out_ready;
      if (m_tk) begin
        midx++;
        if (midx == 8) begin
          void'(mq.pop_front());
          midx = 0;
        end
      end
      if (m_acc) mq.push_back(in_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int id, input logic ir, input logic ov, input logic ob,
                           input logic [2:0] s, input logic fl, input logic bsy);
    bit         msb;
    bit         valid;
    int         pos;
    logic       ebit;
    string      p;
    msb   = (id == 1);
    valid = (mq.size() > 0);
    pos   = msb ? 7 - midx : midx;
    ebit  = valid ? mq[0][pos] : msb;
    p     = $sformatf("dut%0d ", id);
    chk({p, "in_ready"},   32'(ir),  32'(mq.size() < 2));
    chk({p, "out_valid"},  32'(ov),  32'(valid));
    chk({p, "busy"},       32'(bsy), 32'(valid));
    chk({p, "frame_last"}, 32'(fl),  32'(valid && midx == 7));
    chk({p, "sel"},        32'(s),   32'(pos));
    chk({p, "out_bit"},    32'(ob),  32'(ebit));
  endtask

  bit         cap_bit0[$], cap_bit1[$], cap_last0[$];
  logic [2:0] cap_sel0[$], cap_sel1[$];

  always @(negedge clk) begin
    check_dut(0, bus0.in_ready, bus0.out_valid, bus0.out_bit, bus0.sel, bus0.frame_last,
              bus0.busy);
    check_dut(1, bus1.in_ready, bus1.out_valid, bus1.out_bit, bus1.sel, bus1.frame_last,
              bus1.busy);
    if (!rst && out_ready) begin
      if (bus0.out_valid) begin
        cap_bit0.push_back(bus0.out_bit);
        cap_sel0.push_back(bus0.sel);
        cap_last0.push_back(bus0.frame_last);
      end
      if (bus1.out_valid) begin
        cap_bit1.push_back(bus1.out_bit);
        cap_sel1.push_back(bus1.sel);
      end
    end
  end

  function automatic logic [31:0] pack_bits(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  function automatic logic [31:0] pack_sel(input logic [2:0] q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[28:0], q[i]};
    return v;
  endfunction

  task automatic clear_caps();
    cap_bit0.delete();
    cap_bit1.delete();
    cap_last0.delete();
    cap_sel0.delete();
    cap_sel1.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " in_ready0"},   32'(bus0.in_ready),   32'd1);
    chk({nm, " out_valid0"},  32'(bus0.out_valid),  32'd0);
    chk({nm, " out_bit0"},    32'(bus0.out_bit),    32'd0);
    chk({nm, " out_bit1"},    32'(bus1.out_bit),    32'd1);
    chk({nm, " sel0"},        32'(bus0.sel),        32'd0);
    chk({nm, " sel1"},        32'(bus1.sel),        32'd7);
    chk({nm, " frame_last0"}, 32'(bus0.frame_last), 32'd0);
    chk({nm, " busy1"},       32'(bus1.busy),       32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;

    // Single frame A5: same bit sequence both ways, opposite sel ramps.
    clear_caps();
    send(8'hA5);
    repeat (10) step();
    chk("a5 count0", 32'(cap_bit0.size()), 32'd8);
    chk("a5 bits0", pack_bits(cap_bit0), 32'hA5);
    chk("a5 bits1", pack_bits(cap_bit1), 32'hA5);
    chk("a5 sel0", pack_sel(cap_sel0), 32'o01234567);
    chk("a5 sel1", pack_sel(cap_sel1), 32'o76543210);
    chk("a5 last0", pack_bits(cap_last0), 32'h01);
    chk("a5 idle out_bit0", 32'(bus0.out_bit), 32'd0);
    chk("a5 idle out_valid0", 32'(bus0.out_valid), 32'd0);

    // FF then 00 through the holding buffer.
    clear_caps();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_data = 8'h00;
    step();
    in_valid = 1'b0;
    chk("hold in_ready0", 32'(bus0.in_ready), 32'd0);
    repeat (18) step();
    chk("ff00 count0", 32'(cap_bit0.size()), 32'd16);
    chk("ff00 bits0", pack_bits(cap_bit0), 32'hFF00);
    chk("ff00 bits1", pack_bits(cap_bit1), 32'hFF00);

    // 3C with stalls.
    clear_caps();
    send(8'h3C);
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3 == 0);
      step();
    end
    out_ready = 1'b1;
    chk("3c count0", 32'(cap_bit0.size()), 32'd8);
    chk("3c bits0", pack_bits(cap_bit0), 32'h3C);
    chk("3c sel1", pack_sel(cap_sel1), 32'o76543210);

    // Reset at bit 4 with a held word.
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre-rst sel0", 32'(bus0.sel), 32'd4);
    chk("pre-rst in_ready0", 32'(bus0.in_ready), 32'd0);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    clear_caps();
    send(8'h81);
    repeat (10) step();
    chk("81 count1", 32'(cap_bit1.size()), 32'd8);
    chk("81 bits0", pack_bits(cap_bit0), 32'h81);
    chk("81 sel0", pack_sel(cap_sel0), 32'o01234567);

    // New word offered exactly on the last-bit edge with the hold empty.
    clear_caps();
    send(8'h5A);
    for (int i = 0; i < 20 && !bus0.frame_last; i++) step();
    chk("wait frame_last0", 32'(bus0.frame_last), 32'd1);
    send(8'hC3);
    chk("bypass out_valid0", 32'(bus0.out_valid), 32'd1);
    chk("bypass sel1", 32'(bus1.sel), 32'd7);
    repeat (10) step();
    chk("bypass bits0", pack_bits(cap_bit0), 32'h5AC3);

    // Random traffic with occasional resets; the compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
